// File: rtl/vxe_mem_resp_model_pkg.sv
// Shared definitions for the memory-side responder: mode encodings, issue FSM
// states and the stamp width used for latency tracking.
package vxe_mem_resp_model_pkg;

  localparam int STAMP_W = 8;

  localparam logic MODE_SEQ  = 1'b0;
  localparam logic MODE_ADDR = 1'b1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } issue_st_e;

  // Terminator marker for a given data word: every bit set.
  function automatic logic is_all_ones64(input logic [63:0] w, input int width);
    logic res;
    res = 1'b1;
    for (int b = 0; b < 64; b++) begin
      if (b < width && !w[b]) res = 1'b0;
    end
    return res;
  endfunction

endpackage

// File: rtl/vxe_fifo.sv
// Small show-ahead FIFO used as the request tracker; dout always presents the head entry.
module vxe_fifo #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH_POW2 = 2
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic                  clr,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  empty
);

  localparam int DEPTH = 1 << DEPTH_POW2;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DEPTH_POW2:0]   wp;
  logic [DEPTH_POW2:0]   rp;
  logic                  full;

  assign empty = (wp == rp);
  assign full  = (wp[DEPTH_POW2] != rp[DEPTH_POW2]) &&
                 (wp[DEPTH_POW2-1:0] == rp[DEPTH_POW2-1:0]);
  assign dout  = mem[rp[DEPTH_POW2-1:0]];

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      wp <= '0;
      rp <= '0;
    end else if (clr) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (push && !full) wp <= wp + 1'b1;
      if (pop && !empty) rp <= rp + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full) mem[wp[DEPTH_POW2-1:0]] <= din;
  end

endmodule

// File: rtl/vxe_mem_resp_model.sv
// Memory-side responder: accepts requests, tracks them with an accept stamp and
// returns status/data pairs from a run-time loaded content memory.
//
// state   | meaning
// ST_IDLE | no beat on the response FIFOs, waiting for an eligible head
// ST_SEND | beat presented with both wr strobes high until both FIFOs take it
module vxe_mem_resp_model
  import vxe_mem_resp_model_pkg::*;
#(
  parameter int RQA_W    = 44,
  parameter int RSS_W    = 9,
  parameter int RSD_W    = 64,
  parameter int MEMIW    = 8,
  parameter int TRK_POW2 = 2,
  parameter int LATENCY  = 0,
  parameter int ADDR_LSB = 0
) (
  input  logic                clk,
  input  logic                nrst,
  input  logic                i_srst,
  input  logic                i_mode,
  input  logic                i_rqa_vld,
  input  logic [RQA_W-1:0]    i_rqa,
  output logic                o_rqa_rd,
  input  logic                i_rss_rdy,
  output logic [RSS_W-1:0]    o_rss,
  output logic                o_rss_wr,
  input  logic                i_rsd_rdy,
  output logic [RSD_W-1:0]    o_rsd,
  output logic                o_rsd_wr,
  input  logic                i_ld_wr,
  input  logic [MEMIW-1:0]    i_ld_idx,
  input  logic [RSD_W-1:0]    i_ld_data,
  input  logic [RSS_W-1:0]    i_ld_rss,
  output logic [TRK_POW2:0]   o_pending,
  output logic [MEMIW-1:0]    o_seq_idx
);

  localparam int DEPTH = 1 << TRK_POW2;
  localparam int ENT_W = MEMIW + STAMP_W;
  localparam int OCC_W = TRK_POW2 + 1;
  localparam logic [RSD_W-1:0] TERM = '1;

  logic [RSD_W-1:0]   mem_data [2**MEMIW];
  logic [RSS_W-1:0]   mem_rss  [2**MEMIW];

  logic [STAMP_W-1:0] cyc_cnt;
  logic [STAMP_W-1:0] age;
  logic               mode_q;
  logic               mode_eff;
  issue_st_e          state;

  logic               accept;
  logic               beat_done;
  logic               trk_elig;
  logic               in_elig;
  logic               take;
  logic               bypass;
  logic               trk_push;
  logic               trk_pop;
  logic               trk_empty;
  logic [ENT_W-1:0]   trk_din;
  logic [ENT_W-1:0]   trk_dout;
  logic [MEMIW-1:0]   req_idx;
  logic [MEMIW-1:0]   head_idx;
  logic [MEMIW-1:0]   rd_idx;
  logic [RSD_W-1:0]   rd_data;
  logic [RSS_W-1:0]   rd_rss;
  logic               is_term;
  logic               seq_adv;
  logic [RSS_W-1:0]   beat_rss;
  logic [RSD_W-1:0]   beat_rsd;
  logic [OCC_W-1:0]   occ_nxt;

  // Mode follows the pin only while nothing is tracked, so all entries share one mode.
  assign mode_eff  = trk_empty ? i_mode : mode_q;

  assign accept    = i_rqa_vld && o_rqa_rd && !i_srst;
  assign req_idx   = i_rqa[ADDR_LSB +: MEMIW];
  assign trk_din   = {req_idx, cyc_cnt};
  assign beat_done = i_rss_rdy && i_rsd_rdy;

  assign age       = cyc_cnt - trk_dout[STAMP_W-1:0];
  assign trk_elig  = !trk_empty && (int'(age) >= LATENCY);
  // With zero latency an incoming request may issue in its own accept cycle.
  assign in_elig   = accept && trk_empty && (LATENCY == 0);
  assign take      = !i_srst && (trk_elig || in_elig) && ((state == ST_IDLE) || beat_done);
  assign bypass    = take && !trk_elig;
  assign trk_pop   = take && trk_elig;
  assign trk_push  = accept && !bypass;

  assign head_idx  = trk_elig ? trk_dout[ENT_W-1 -: MEMIW] : req_idx;
  assign rd_idx    = (mode_eff == MODE_ADDR) ? head_idx : o_seq_idx;
  assign rd_data   = mem_data[rd_idx];
  assign rd_rss    = mem_rss[rd_idx];
  assign is_term   = (mode_eff == MODE_SEQ) && (rd_data == TERM);
  assign seq_adv   = (mode_eff == MODE_SEQ) && !is_term;
  assign beat_rss  = is_term ? '0 : rd_rss;
  assign beat_rsd  = is_term ? '0 : rd_data;

  assign occ_nxt   = o_pending + OCC_W'(trk_push) - OCC_W'(trk_pop);

  vxe_fifo #(
    .DATA_WIDTH (ENT_W),
    .DEPTH_POW2 (TRK_POW2)
  ) u_trk (
    .clk   (clk),
    .nrst  (nrst),
    .clr   (i_srst),
    .push  (trk_push),
    .pop   (trk_pop),
    .din   (trk_din),
    .dout  (trk_dout),
    .empty (trk_empty)
  );

  always_ff @(posedge clk) begin
    if (i_ld_wr) begin
      mem_data[i_ld_idx] <= i_ld_data;
      mem_rss[i_ld_idx]  <= i_ld_rss;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state     <= ST_IDLE;
      cyc_cnt   <= '0;
      mode_q    <= MODE_SEQ;
      o_pending <= '0;
      o_rqa_rd  <= 1'b0;
      o_rss     <= '0;
      o_rsd     <= '0;
      o_rss_wr  <= 1'b0;
      o_rsd_wr  <= 1'b0;
      o_seq_idx <= '0;
    end else if (i_srst) begin
      state     <= ST_IDLE;
      cyc_cnt   <= '0;
      mode_q    <= MODE_SEQ;
      o_pending <= '0;
      o_rqa_rd  <= 1'b0;
      o_rss     <= '0;
      o_rsd     <= '0;
      o_rss_wr  <= 1'b0;
      o_rsd_wr  <= 1'b0;
      o_seq_idx <= '0;
    end else begin
      cyc_cnt   <= cyc_cnt + 1'b1;
      mode_q    <= mode_eff;
      o_pending <= occ_nxt;
      // Keep one slot spare so a pop already in flight is always absorbed.
      o_rqa_rd  <= (int'(occ_nxt) <= DEPTH - 2);
      if (take) begin
        state    <= ST_SEND;
        o_rss    <= beat_rss;
        o_rsd    <= beat_rsd;
        o_rss_wr <= 1'b1;
        o_rsd_wr <= 1'b1;
        if (seq_adv) o_seq_idx <= o_seq_idx + 1'b1;
      end else if (state == ST_SEND && beat_done) begin
        state    <= ST_IDLE;
        o_rss_wr <= 1'b0;
        o_rsd_wr <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_vxe_mem_resp_model.sv
// Scoreboard bench for vxe_mem_resp_model: one zero-latency instance for stream,
// address, backpressure and soft-reset traffic, one small long-latency instance.
module tb_vxe_mem_resp_model;

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic        srst = 1'b0;
  logic        mode = 1'b0;
  logic        rqa_vld = 1'b0;
  logic [43:0] rqa = '0;
  logic        rss_rdy = 1'b1;
  logic        rsd_rdy = 1'b1;
  logic        ld_wr_a = 1'b0;
  logic        ld_wr_b = 1'b0;
  logic [7:0]  ld_idx = '0;
  logic [63:0] ld_data = '0;
  logic [8:0]  ld_rss = '0;

  logic        rqa_rd, rss_wr, rsd_wr;
  logic [8:0]  rss;
  logic [63:0] rsd;
  logic [2:0]  pending;
  logic [7:0]  seq_idx;

  logic        b_srst = 1'b0;
  logic        b_mode = 1'b0;
  logic        b_vld = 1'b0;
  logic [43:0] b_rqa = '0;
  logic        b_rdy = 1'b1;
  logic        b_rd, b_rss_wr, b_rsd_wr;
  logic [8:0]  b_rss;
  logic [63:0] b_rsd;
  logic [2:0]  b_pending;
  logic [1:0]  b_seq;

  vxe_mem_resp_model #(.LATENCY(0), .ADDR_LSB(3)) dut (
    .clk(clk), .nrst(nrst), .i_srst(srst), .i_mode(mode),
    .i_rqa_vld(rqa_vld), .i_rqa(rqa), .o_rqa_rd(rqa_rd),
    .i_rss_rdy(rss_rdy), .o_rss(rss), .o_rss_wr(rss_wr),
    .i_rsd_rdy(rsd_rdy), .o_rsd(rsd), .o_rsd_wr(rsd_wr),
    .i_ld_wr(ld_wr_a), .i_ld_idx(ld_idx), .i_ld_data(ld_data), .i_ld_rss(ld_rss),
    .o_pending(pending), .o_seq_idx(seq_idx)
  );

  vxe_mem_resp_model #(.MEMIW(2), .LATENCY(10), .ADDR_LSB(0)) dut_b (
    .clk(clk), .nrst(nrst), .i_srst(b_srst), .i_mode(b_mode),
    .i_rqa_vld(b_vld), .i_rqa(b_rqa), .o_rqa_rd(b_rd),
    .i_rss_rdy(b_rdy), .o_rss(b_rss), .o_rss_wr(b_rss_wr),
    .i_rsd_rdy(b_rdy), .o_rsd(b_rsd), .o_rsd_wr(b_rsd_wr),
    .i_ld_wr(ld_wr_b), .i_ld_idx(ld_idx[1:0]), .i_ld_data(ld_data), .i_ld_rss(ld_rss),
    .o_pending(b_pending), .o_seq_idx(b_seq)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference content and stream pointer for the main instance.
  logic [63:0] m_d [256];
  logic [8:0]  m_s [256];
  int          m_seq = 0;
  logic [72:0] exp_q [$];
  logic        mon_en = 1'b0;
  logic        stalled = 1'b0;
  logic [72:0] held = '0;
  logic [63:0] b_obs [$];

  always @(negedge clk) begin
    #2;
    if (mon_en && !srst) begin
      if (rss_wr || rsd_wr) chk("wr_pair", rss_wr, rsd_wr);
      if (stalled) chk("hold", {rss, rsd}, held);
      stalled = 1'b0;
      if (rss_wr && rss_rdy && rsd_rdy) begin
        if (exp_q.size() == 0) chk("extra_beat", exp_q.size(), 1);
        else chk("resp", {rss, rsd}, exp_q.pop_front());
      end else if (rss_wr) begin
        stalled = 1'b1;
        held = {rss, rsd};
      end
    end else begin
      stalled = 1'b0;
    end
  end

  always @(negedge clk) begin
    #2;
    if (b_rss_wr) b_obs.push_back(b_rsd);
  end

  task automatic ld(input int idx, input logic [63:0] d, input logic [8:0] s, input bit to_b);
    ld_idx  = 8'(idx);
    ld_data = d;
    ld_rss  = s;
    if (to_b) ld_wr_b = 1'b1;
    else begin
      ld_wr_a = 1'b1;
      m_d[idx] = d;
      m_s[idx] = s;
    end
    @(negedge clk);
    ld_wr_a = 1'b0;
    ld_wr_b = 1'b0;
  endtask

  task automatic model_push(input logic [43:0] a);
    logic [7:0] i;
    if (mode) begin
      i = a[10:3];
      exp_q.push_back({m_s[i], m_d[i]});
    end else if (m_d[m_seq] == {64{1'b1}}) begin
      exp_q.push_back('0);
    end else begin
      exp_q.push_back({m_s[m_seq], m_d[m_seq]});
      m_seq = (m_seq + 1) % 256;
    end
  endtask

  task automatic push_req(input logic [43:0] a);
    int g = 0;
    rqa_vld = 1'b1;
    rqa = a;
    while (!rqa_rd && g < 100) begin
      @(negedge clk);
      g++;
    end
    if (g >= 100) chk("rqa_rd_timeout", g, 0);
    else model_push(a);
    @(negedge clk);
    rqa_vld = 1'b0;
  endtask

  task automatic push_b(output int acc_cyc);
    int g = 0;
    b_vld = 1'b1;
    while (!b_rd && g < 100) begin
      @(negedge clk);
      g++;
    end
    if (g >= 100) chk("b_rd_timeout", g, 0);
    @(negedge clk);
    acc_cyc = cyc;
    b_vld = 1'b0;
  endtask

  task automatic drain();
    int g = 0;
    while ((exp_q.size() != 0 || rss_wr) && g < 300) begin
      @(negedge clk);
      g++;
    end
    chk("drain", exp_q.size(), 0);
  endtask

  initial begin
    int a;
    int g;
    repeat (3) @(negedge clk);
    chk("rst_rqa_rd", rqa_rd, 0);
    chk("rst_wr", {rss_wr, rsd_wr}, 0);
    chk("rst_data", {rss, rsd}, 0);
    chk("rst_pending", pending, 0);
    chk("rst_seq", seq_idx, 0);
    nrst = 1'b1;
    @(negedge clk);
    chk("rqa_rd_up", rqa_rd, 1);

    for (int i = 0; i < 4; i++) ld(i, 64'h11 + 64'(i), 9'(i + 1), 1'b0);
    ld(4, {64{1'b1}}, 9'h1ff, 1'b0);
    for (int i = 0; i < 4; i++) ld(i, 64'hB0 + 64'(i), 9'(i + 8), 1'b1);
    mon_en = 1'b1;

    // Stream mode through the terminator.
    mode = 1'b0;
    m_seq = 0;
    for (int i = 0; i < 6; i++) push_req(44'h0);
    drain();
    chk("seq_idx_term", seq_idx, 4);

    // Address mode, index taken from bit 3 upward.
    mode = 1'b1;
    push_req(44'h18);
    push_req(44'h08);
    drain();
    chk("seq_idx_addr_hold", seq_idx, 4);

    // Data FIFO backpressure with the tracker filling to the stall point.
    rsd_rdy = 1'b0;
    push_req(44'h10);
    push_req(44'h20);
    push_req(44'h18);
    push_req(44'h08);
    chk("prefull_rd", rqa_rd, 0);
    chk("prefull_pending", pending, 3);
    repeat (5) @(negedge clk);
    rsd_rdy = 1'b1;
    push_req(44'h00);
    push_req(44'h10);
    drain();
    chk("rd_recover", rqa_rd, 1);

    // Soft reset with one beat stalled and two tracked.
    rsd_rdy = 1'b0;
    push_req(44'h08);
    push_req(44'h18);
    push_req(44'h10);
    chk("pre_srst_pending", pending, 2);
    srst = 1'b1;
    @(negedge clk);
    srst = 1'b0;
    exp_q.delete();
    chk("srst_wr", {rss_wr, rsd_wr}, 0);
    chk("srst_pending", pending, 0);
    chk("srst_seq", seq_idx, 0);
    rsd_rdy = 1'b1;
    mode = 1'b0;
    m_seq = 0;
    push_req(44'h0);
    push_req(44'h0);
    drain();

    // Long-latency, narrow-index instance: latency then wrap.
    push_b(a);
    g = 0;
    while (!b_rss_wr && g < 50) begin
      @(negedge clk);
      g++;
    end
    chk("lat_first_wr", cyc - a, 10);
    for (int i = 0; i < 4; i++) push_b(a);
    g = 0;
    while (b_obs.size() < 5 && g < 200) begin
      @(negedge clk);
      g++;
    end
    chk("b_count", b_obs.size(), 5);
    chk("b_first", b_obs[0], 64'hB0);
    chk("b_fourth", b_obs[3], 64'hB3);
    chk("wrap_data", b_obs[4], 64'hB0);
    chk("wrap_seq", b_seq, 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout got=%0d exp=done", cyc);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/vxe_mem_resp_model.md
# vxe_mem_resp_model

Parametrised memory-side responder for unit-level benches and FPGA bring-up. It consumes requests from a request FIFO and returns status/data pairs into response status/data FIFOs, with configurable request tracking depth, response latency and addressing mode (sequential stream or address-indexed). Response content is loaded at run time through a load port. It replaces ad-hoc per-bench traffic logic in front of the fetch unit and other memory clients.

## Interface
- RQA_W, 44: request word width.
- RSS_W, 9: response status width.
- RSD_W, 64: response data width.
- MEMIW, 8: content memory index width; 2**MEMIW entries.
- TRK_POW2, 2: log2 of the request tracker depth.
- LATENCY, 0: minimum cycles from request accept to response issue; valid range 0..255.
- ADDR_LSB, 0: request bit at which the memory index starts in address mode.

- clk  in  1  clock
- nrst  in  1  async reset, active low
- i_srst  in  1  sync soft reset; same effect as nrst, content memory untouched
- i_mode  in  1  0 = sequential, 1 = address-indexed; sampled only while tracker empty
- i_rqa_vld  in  1  request FIFO not empty
- i_rqa  in  RQA_W  request FIFO head
- o_rqa_rd  out  1  request pop
- i_rss_rdy  in  1  status FIFO can accept
- o_rss  out  RSS_W  response status
- o_rss_wr  out  1  status write
- i_rsd_rdy  in  1  data FIFO can accept
- o_rsd  out  RSD_W  response data
- o_rsd_wr  out  1  data write
- i_ld_wr  in  1  content load strobe
- i_ld_idx  in  MEMIW  load index
- i_ld_data  in  RSD_W  load data
- i_ld_rss  in  RSS_W  load status
- o_pending  out  TRK_POW2+1  requests accepted, not yet issued
- o_seq_idx  out  MEMIW  current sequential index

## Operation
- Reset (nrst low or i_srst high): o_rqa_rd, o_rss_wr, o_rsd_wr = 0; o_rss, o_rsd = 0; o_pending = 0; o_seq_idx = 0; cycle counter = 0; tracker flushed. Content memory not reset.
- Accept: request taken on a cycle with i_rqa_vld && o_rqa_rd. o_rqa_rd registered; deasserted when free tracker slots < 2 after the current cycle, reasserted when ≥ 2 (pre-full stall, absorbs one in-flight pop).
- Tracker entry: {index, stamp}. Index = i_rqa[ADDR_LSB +: MEMIW] in address mode, don't-care in sequential mode. Stamp = 8-bit free-running cycle counter at accept.
- Head eligible when (counter − stamp) mod 256 ≥ LATENCY.
- Issue FSM, states IDLE / SEND:
  - IDLE: if head eligible, load o_rss/o_rsd, assert both wr, pop tracker, go SEND.
  - SEND: a beat completes when i_rss_rdy && i_rsd_rdy. On completion: if a further head is eligible, load next beat, pop, stay in SEND (back-to-back); otherwise drop both wr, go IDLE. Without completion, hold data and wr.
- o_rss_wr and o_rsd_wr are always equal; one status per data word.
- Sequential mode: entry = memory[o_seq_idx]. If data == all ones (terminator), issue rss = 0, rsd = 0, index not advanced; otherwise issue {ld_rss, ld_data} and o_seq_idx increments, wrapping 2**MEMIW−1 → 0.
- Address mode: entry = memory[index]; no terminator handling; o_seq_idx held.
- Load on the same cycle and index as an issue: issue sees the old content.
- i_mode change while tracker non-empty is ignored until empty.

## Timing
- Request accepted at cycle T: earliest o_rss_wr high at T+1+LATENCY.
- Steady state with rdy high and LATENCY met: one response per cycle.
- Throughput with TRK_POW2=2: up to 3 outstanding before o_rqa_rd drops.
- Simultaneous accept and issue: o_pending unchanged.
- Soft reset mid-SEND: wr dropped next edge, pending responses discarded.

## Structure
- Shared defines header: terminator constant (all ones of RSD_W), mode encodings, FSM state encodings.
- Tracker is one vxe_fifo instance (DATA_WIDTH = MEMIW+8, DEPTH_POW2 = TRK_POW2); occupancy counter kept locally for the pre-full stall.
- Content memory and issue FSM in the top module.

## Test plan
- Sequential, LATENCY=0: load words 0x11..0x14, rss 0x001..0x004, word 4 = terminator; 6 requests → responses 0x11,0x12,0x13,0x14, then two rss=0/rsd=0; o_seq_idx = 4.
- LATENCY=10: single request accepted at T → o_rss_wr first high at T+11, not earlier.
- Address mode, ADDR_LSB=3: requests with addr 0x18, 0x08 → data of entries 3 then 1 in request order.
- Backpressure: i_rsd_rdy low 5 cycles mid-stream → o_rss/o_rsd held stable, no loss or duplication; o_rqa_rd drops at 3 outstanding, recovers.
- Wrap: MEMIW=2, 5 non-terminator requests → fifth returns entry 0, o_seq_idx = 1.
- i_srst during SEND with 2 pending → wr low next cycle, o_pending = 0, memory content intact on rerun.
